cpu_mc: RTL and testbench
=========================

# cpu_mc

Multi-cycle successor to the single-cycle Hack-style core, with a parametrised data width. It fetches 32-bit instruction words, each holding two 16-bit slots, from a synchronous ROM. It dual-issues an A-instruction followed by a non-jumping C-instruction, and reaches data memory through a req/ack handshake so that memory may take any number of cycles. It adds a sticky halt detector and a retired-instruction counter for the bench and the board LEDs.

## Interface
Parameters:
- PC_WIDTH, 16: instruction-slot address width. pc[0] selects the slot within a word.
- DATA_W, 16: width of A, D, ALU and memory data. Must be at least 16. The A-immediate is zero-extended to this width.
- DUAL_ISSUE, 1: 1 enables A+C pairing; 0 always single-issues.

Ports:
- clk  in  1  clock
- resetN  in  1  reset; asynchronous, active-low
- inst  in  32  instruction word; slot0 = [15:0], slot1 = [31:16]
- inst_valid  in  1  inst holds the word at the last presented inst_addr
- inst_addr  out  PC_WIDTH-1  word address for the synchronous ROM
- dm_req  out  1  data-memory request
- dm_we  out  1  1 = write, 0 = read
- dm_addr  out  15  data address
- dm_wdata  out  DATA_W  write data
- dm_rdata  in  DATA_W  read data; valid in the dm_ack cycle
- dm_ack  in  1  request completes at this clock edge
- halted  out  1  sticky halt flag
- instret  out  32  retired-slot count

## Operation
- Encoding (per slot):
  - bit15 = 0: A-instruction. A <= {0, imm15}.
  - bit15 = 1: C-instruction. bit12 = AM select; [11:6] = ALU fn {zx,nx,zy,ny,f,no}; [5:3] = dest {A,D,M}; [2:0] = jump {LT,EQ,GT}.
- ALU: x = D; y = AM ? M : A. Flags: zero = (out == 0); lt = out[DATA_W-1]; gt = !lt && !zero.
- Dual issue: taken when DUAL_ISSUE=1, pc[0]=0, slot0 is an A-instruction, and slot1 is a C-instruction with jump bits 000.
  - The pair retires as one unit and pc advances by 2.
  - The ALU's A operand and dm_addr use slot0's imm.
  - Final A = alu_out if slot1 has dest A, else imm.
- Otherwise the slot at pc[0] executes alone and pc advances by 1.
- Jump target = A[PC_WIDTH-1:0], using A's value before the jumping instruction writes it.
- FSM states RUN, RD_WAIT, WR_WAIT:
  - RUN, inst_valid=0: no state change.
  - RUN, no memory access: retire at this edge.
  - RUN, executing C-instruction with AM=1: go to RD_WAIT.
  - RUN, AM=0 and dest M: go to WR_WAIT.
  - RD_WAIT: dm_req=1, dm_we=0. On ack:
    - if dest M: latch dm_rdata into m_q and go to WR_WAIT;
    - else retire using dm_rdata and go to RUN.
  - WR_WAIT: dm_req=1, dm_we=1, dm_wdata = ALU result with M = m_q. On ack: retire and go to RUN.
- dm_addr is stable for the whole request. The FSM never drops dm_req before ack.
- Retire actions: update A, D and pc; instret += 1 or 2. If a jump is taken and its target equals the jumping slot's own address, set halted.
- While halted, the core keeps executing the self-loop. instret continues counting.

## Timing
- Reset values: pc = 0, A = 0, D = 0, m_q = 0, state = RUN, dm_req = 0, dm_we = 0, halted = 0, instret = 0.
- inst_addr is 0 while resetN is low.
- inst_addr = next_pc[PC_WIDTH-1:1] in a retire cycle, else pc[PC_WIDTH-1:1]. The ROM has 1-cycle latency, so inst is valid the cycle after retirement.
- Latency from decode to retire, with ack in the first wait cycle:
  - no memory access: 1 cycle;
  - read only: 2 cycles;
  - write only: 2 cycles;
  - read-modify-write: 3 cycles.
  - Each extra ack-low cycle adds 1.
- dm_ack while dm_req=0 is ignored.
- Reset asserted mid-request drops dm_req asynchronously. No retirement occurs.
- pc wraps modulo 2^PC_WIDTH. Dual issue is never taken at pc[0]=1.

## Structure
- cpu_mc_pkg holds:
  - state enum (RUN/RD_WAIT/WR_WAIT);
  - bit-position constants for slot fields (A-flag 15, AM 12, C 11:6, dest 5:3, jump 2:0), with the slot1 offset of 16;
  - ALU fn bit names.
- One sub-module: cpu_alu #(W), the combinational Hack ALU with x, y, fn and out, zero outputs. It is instantiated once.

## Test plan
- Word {C: D=D+A, A: @5}, D=3 -> dual issue; after 1 cycle A=5, D=8, pc += 2, instret = 2, dm_req never asserted.
- A: @100 then slot1 C: M=M+1, mem[100]=41, ack latency 3 -> read then write.
  - dm_addr = 100 throughout; dm_wdata = 42.
  - Retires 2 cycles after the write request is asserted.
  - mem[100] = 42.
- Slot1 C-instruction D;JEQ with D=0 and A=7 -> not dual-issued; slot0 retires first, then pc = 7.
- Jump D;JMP at address 9 with A=9 -> halted rises at the retire edge and stays high; instret keeps incrementing.
- resetN pulsed low during RD_WAIT -> dm_req=0 immediately; pc=0, A=0, D=0, instret=0; core restarts at word 0.
- DUAL_ISSUE=0, DATA_W=24, A: @32767, then D=!A -> D=0xFF8000; every retire increments instret by 1.

Source files
------------

// File: rtl/cpu_mc_pkg.sv
// Shared types and instruction-field positions for the multi-cycle Hack-style core.
package cpu_mc_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    localparam int DM_ADDR_W = 15;

    // Slot field positions (slot1 sits SLOT1_OFS bits above slot0 in the word)
    localparam int SLOT_W    = 16;
    localparam int SLOT1_OFS = 16;
    localparam int BIT_AFLAG = 15;
    localparam int BIT_AM    = 12;
    localparam int FN_HI     = 11;
    localparam int FN_LO     = 6;
    localparam int DEST_HI   = 5;
    localparam int DEST_LO   = 3;
    localparam int JMP_HI    = 2;
    localparam int JMP_LO    = 0;

    // Bits within the dest and jump fields
    localparam int DEST_A = 2;
    localparam int DEST_D = 1;
    localparam int DEST_M = 0;
    localparam int JMP_LT = 2;
    localparam int JMP_EQ = 1;
    localparam int JMP_GT = 0;

    // Bits within the 6-bit ALU function field
    localparam int FN_ZX = 5;
    localparam int FN_NX = 4;
    localparam int FN_ZY = 3;
    localparam int FN_NY = 2;
    localparam int FN_F  = 1;
    localparam int FN_NO = 0;

endpackage

// File: rtl/cpu_mc_if.sv
// Data-memory request/acknowledge bus between the core and its memory.
interface cpu_mc_if
    import cpu_mc_pkg::*;
#(
    parameter int DATA_W = 16
);
    logic                 dm_req;
    logic                 dm_we;
    logic [DM_ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0]    dm_wdata;
    logic [DATA_W-1:0]    dm_rdata;
    logic                 dm_ack;

    modport master (output dm_req, dm_we, dm_addr, dm_wdata, input dm_rdata, dm_ack);
    modport slave  (input dm_req, dm_we, dm_addr, dm_wdata, output dm_rdata, dm_ack);
endinterface

// File: rtl/cpu_alu.sv
// Combinational Hack ALU: optional zero/negate of each operand, add or and, optional negate.
module cpu_alu
    import cpu_mc_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_y,
    input  logic [5:0]   i_fn,
    output logic [W-1:0] o_out,
    output logic         o_zero
);
    logic [W-1:0] w_x0, w_x1, w_y0, w_y1, w_res;

    assign w_x0   = i_fn[FN_ZX] ? '0 : i_x;
    assign w_x1   = i_fn[FN_NX] ? ~w_x0 : w_x0;
    assign w_y0   = i_fn[FN_ZY] ? '0 : i_y;
    assign w_y1   = i_fn[FN_NY] ? ~w_y0 : w_y0;
    assign w_res  = i_fn[FN_F] ? (w_x1 + w_y1) : (w_x1 & w_y1);
    assign o_out  = i_fn[FN_NO] ? ~w_res : w_res;
    assign o_zero = (o_out == '0);
endmodule

// File: rtl/cpu_mc.sv
// Multi-cycle Hack-style core: two-slot instruction words, optional A+C pairing,
// handshaked data memory, sticky self-loop halt detection and retired-slot counter.
//
// state   | meaning
// RUN     | decode the current slot(s); retire at once if no memory access
// RD_WAIT | read request outstanding for the M operand
// WR_WAIT | write request outstanding for the M destination
module cpu_mc
    import cpu_mc_pkg::*;
#(
    parameter int PC_WIDTH   = 16,
    parameter int DATA_W     = 16,
    parameter int DUAL_ISSUE = 1
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic [31:0]         inst,
    input  logic                inst_valid,
    output logic [PC_WIDTH-2:0] inst_addr,
    cpu_mc_if.master            dm,
    output logic                halted,
    output logic [31:0]         instret
);
    state_t               r_state, w_state_nxt;
    logic [PC_WIDTH-1:0]  r_pc, w_pc_nxt, w_pc_inc, w_target;
    logic [DATA_W-1:0]    r_a, r_d, r_mq, w_a_nxt, w_d_nxt;
    logic                 r_halted;
    logic [31:0]          r_instret;

    logic [SLOT_W-1:0]    w_slot0, w_slot1, w_slot_cur, w_cins;
    logic [14:0]          w_imm_src;
    logic [DATA_W-1:0]    w_imm, w_a_op, w_m_val, w_alu_y, w_alu_out;
    logic [2:0]           w_dest, w_jmp;
    logic                 w_dual, w_is_c, w_am, w_dest_a, w_dest_d, w_dest_m;
    logic                 w_alu_zero, w_lt, w_gt, w_jump, w_halt_set;
    logic                 w_retire, w_mq_load;

    // Decode: pairing applies only to an A-slot followed by a non-jumping C-slot in one word
    assign w_slot0    = inst[SLOT_W-1:0];
    assign w_slot1    = inst[SLOT1_OFS +: SLOT_W];
    assign w_slot_cur = r_pc[0] ? w_slot1 : w_slot0;
    assign w_dual     = (DUAL_ISSUE != 0) && !r_pc[0] && !w_slot0[BIT_AFLAG]
                        && w_slot1[BIT_AFLAG] && (w_slot1[JMP_HI:JMP_LO] == 3'b000);
    assign w_cins     = w_dual ? w_slot1 : w_slot_cur;
    assign w_is_c     = w_cins[BIT_AFLAG];
    assign w_imm_src  = w_dual ? w_slot0[14:0] : w_slot_cur[14:0];
    assign w_imm      = {{(DATA_W-15){1'b0}}, w_imm_src};
    assign w_a_op     = w_dual ? w_imm : r_a;
    assign w_am       = w_is_c && w_cins[BIT_AM];
    assign w_dest     = w_cins[DEST_HI:DEST_LO];
    assign w_jmp      = w_cins[JMP_HI:JMP_LO];
    assign w_dest_a   = w_is_c && w_dest[DEST_A];
    assign w_dest_d   = w_is_c && w_dest[DEST_D];
    assign w_dest_m   = w_is_c && w_dest[DEST_M];

    // M comes straight from the bus in the read-ack cycle, otherwise from the latched copy
    assign w_m_val = (r_state == RD_WAIT) ? dm.dm_rdata : r_mq;
    assign w_alu_y = w_am ? w_m_val : w_a_op;

    cpu_alu #(.W(DATA_W)) u_alu (
        .i_x    (r_d),
        .i_y    (w_alu_y),
        .i_fn   (w_cins[FN_HI:FN_LO]),
        .o_out  (w_alu_out),
        .o_zero (w_alu_zero)
    );

    assign w_lt       = w_alu_out[DATA_W-1];
    assign w_gt       = !w_lt && !w_alu_zero;
    assign w_jump     = w_is_c && ((w_jmp[JMP_LT] && w_lt) || (w_jmp[JMP_EQ] && w_alu_zero)
                                   || (w_jmp[JMP_GT] && w_gt));
    assign w_target   = r_a[PC_WIDTH-1:0];
    assign w_pc_inc   = w_dual ? PC_WIDTH'(2) : PC_WIDTH'(1);
    assign w_pc_nxt   = w_jump ? w_target : (r_pc + w_pc_inc);
    assign w_halt_set = w_jump && (w_target == r_pc);
    assign w_a_nxt    = !w_is_c ? w_imm : (w_dest_a ? w_alu_out : w_a_op);
    assign w_d_nxt    = w_dest_d ? w_alu_out : r_d;

    // State register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_state <= RUN;
        else         r_state <= w_state_nxt;
    end

    // Next state, retire strobe and M latch strobe
    always_comb begin
        w_state_nxt = r_state;
        w_retire    = 1'b0;
        w_mq_load   = 1'b0;
        case (r_state)
            RUN: begin
                if (inst_valid) begin
                    if (w_am)          w_state_nxt = RD_WAIT;
                    else if (w_dest_m) w_state_nxt = WR_WAIT;
                    else               w_retire    = 1'b1;
                end
            end
            RD_WAIT: begin
                if (dm.dm_ack) begin
                    if (w_dest_m) begin
                        w_state_nxt = WR_WAIT;
                        w_mq_load   = 1'b1;
                    end else begin
                        w_state_nxt = RUN;
                        w_retire    = 1'b1;
                    end
                end
            end
            WR_WAIT: begin
                if (dm.dm_ack) begin
                    w_state_nxt = RUN;
                    w_retire    = 1'b1;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    // Bus outputs; request follows the registered state so reset drops it at once
    always_comb begin
        dm.dm_req   = (r_state != RUN);
        dm.dm_we    = (r_state == WR_WAIT);
        dm.dm_addr  = w_a_op[DM_ADDR_W-1:0];
        dm.dm_wdata = w_alu_out;
    end

    // Architectural state update at retirement
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_pc      <= '0;
            r_a       <= '0;
            r_d       <= '0;
            r_mq      <= '0;
            r_halted  <= 1'b0;
            r_instret <= '0;
        end else begin
            if (w_mq_load) r_mq <= dm.dm_rdata;
            if (w_retire) begin
                r_pc      <= w_pc_nxt;
                r_a       <= w_a_nxt;
                r_d       <= w_d_nxt;
                r_instret <= r_instret + (w_dual ? 32'd2 : 32'd1);
                if (w_halt_set) r_halted <= 1'b1;
            end
        end
    end

    assign inst_addr = !resetN ? '0 : (w_retire ? w_pc_nxt[PC_WIDTH-1:1] : r_pc[PC_WIDTH-1:1]);
    assign halted    = r_halted;
    assign instret   = r_instret;
endmodule

// File: tb/tb_cpu_mc.sv
// Directed bench for cpu_mc: dual-issue core with memory model, plus a 24-bit single-issue core.
module tb_cpu_mc;
    import cpu_mc_pkg::*;

    logic        clk = 1'b0;
    logic        resetN, resetN2;
    logic [31:0] inst1, inst2;
    logic        valid1, valid2;
    logic [14:0] addr1, addr2;
    logic        halted1, halted2;
    logic [31:0] instret1, instret2;
    logic        force_ack;
    int          rd_lat, wr_lat, cnt;
    logic [31:0] rom1 [0:15];
    logic [31:0] rom2 [0:15];
    logic [15:0] mem  [0:127];
    logic        ack_hit;

    int n_tests = 0;
    int n_fail  = 0;
    int req_seen;
    int cyc, wr_first;

    cpu_mc_if #(.DATA_W(16)) bus1 ();
    cpu_mc_if #(.DATA_W(24)) bus2 ();

    cpu_mc #(.PC_WIDTH(16), .DATA_W(16), .DUAL_ISSUE(1)) dut1 (
        .clk(clk), .resetN(resetN), .inst(inst1), .inst_valid(valid1), .inst_addr(addr1),
        .dm(bus1), .halted(halted1), .instret(instret1));

    cpu_mc #(.PC_WIDTH(16), .DATA_W(24), .DUAL_ISSUE(0)) dut2 (
        .clk(clk), .resetN(resetN2), .inst(inst2), .inst_valid(valid2), .inst_addr(addr2),
        .dm(bus2), .halted(halted2), .instret(instret2));

    always #5 clk = ~clk;

    // Synchronous ROMs, one-cycle latency
    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            valid1 <= 1'b0;
            inst1  <= '0;
        end else begin
            inst1  <= rom1[addr1[3:0]];
            valid1 <= 1'b1;
        end
    end

    always @(posedge clk or negedge resetN2) begin
        if (!resetN2) begin
            valid2 <= 1'b0;
            inst2  <= '0;
        end else begin
            inst2  <= rom2[addr2[3:0]];
            valid2 <= 1'b1;
        end
    end

    // Data memory: ack in the rd_lat-th / wr_lat-th cycle of each request phase
    assign ack_hit       = bus1.dm_req && (cnt == (bus1.dm_we ? wr_lat - 1 : rd_lat - 1));
    assign bus1.dm_ack   = ack_hit || force_ack;
    assign bus1.dm_rdata = mem[bus1.dm_addr[6:0]];
    assign bus2.dm_ack   = 1'b0;
    assign bus2.dm_rdata = '0;

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt      <= 0;
            mem[100] <= 16'd41;
            mem[50]  <= 16'd1234;
        end else if (ack_hit) begin
            if (bus1.dm_we) mem[bus1.dm_addr[6:0]] <= bus1.dm_wdata;
            cnt <= 0;
        end else if (bus1.dm_req) begin
            cnt <= cnt + 1;
        end else begin
            cnt <= 0;
        end
    end

    function automatic logic [15:0] c_ins(input logic am, input logic [5:0] fn,
                                          input logic [2:0] dest, input logic [2:0] jmp);
        return {3'b111, am, fn, dest, jmp};
    endfunction

    function automatic logic [15:0] a_ins(input logic [14:0] imm);
        return {1'b0, imm};
    endfunction

    function automatic logic [31:0] cur_ret(input int which);
        return (which == 0) ? instret1 : instret2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) until the selected core's instret reaches n; cycles counted in negedges
    task automatic wait_ret(input int which, input int n, output int cycles);
        cycles = 0;
        while (cur_ret(which) < n && cycles < 200) begin
            @(negedge clk);
            cycles++;
            if ((which == 0) ? bus1.dm_req : bus2.dm_req) req_seen++;
        end
        if (cur_ret(which) < n) chk("instret_timeout", cur_ret(which), n);
    endtask

    initial begin
        resetN = 1'b0; resetN2 = 1'b0; force_ack = 1'b0;
        rd_lat = 3; wr_lat = 2; req_seen = 0;
        for (int i = 0; i < 16; i++) begin
            rom1[i] = '0;
            rom2[i] = '0;
        end
        rom1[0] = {c_ins(1'b0, 6'b110000, 3'b010, 3'b000), a_ins(15'd3)};    // @3  ; D=A
        rom1[1] = {c_ins(1'b0, 6'b000010, 3'b010, 3'b000), a_ins(15'd5)};    // @5  ; D=D+A
        rom1[2] = {c_ins(1'b1, 6'b110111, 3'b001, 3'b000), a_ins(15'd100)};  // @100; M=M+1
        rom1[3] = {c_ins(1'b0, 6'b110000, 3'b010, 3'b000), a_ins(15'd0)};    // @0  ; D=A
        rom1[4] = {c_ins(1'b0, 6'b001100, 3'b000, 3'b010), a_ins(15'd7)};    // @7  ; D;JEQ
        rom1[5] = {c_ins(1'b0, 6'b001100, 3'b000, 3'b111), a_ins(15'd11)};   // @11 ; D;JMP
        rom2[0] = {c_ins(1'b0, 6'b110001, 3'b010, 3'b000), a_ins(15'd32767)}; // @32767; D=!A
        rom2[1] = {c_ins(1'b0, 6'b000010, 3'b010, 3'b000), a_ins(15'd3)};     // @3  ; D=D+A
        rom2[2] = {c_ins(1'b0, 6'b001100, 3'b000, 3'b111), a_ins(15'd5)};     // @5  ; D;JMP

        repeat (3) @(negedge clk);
        chk("rst_inst_addr", addr1, 0);
        chk("rst_dm_req", bus1.dm_req, 0);
        chk("rst_dm_we", bus1.dm_we, 0);
        chk("rst_halted", halted1, 0);
        chk("rst_instret", instret1, 0);

        // Dual issue without memory; stray acks in RUN must be ignored
        force_ack = 1'b1;
        resetN = 1'b1;
        wait_ret(0, 2, cyc);
        chk("dual0_a", dut1.r_a, 3);
        chk("dual0_d", dut1.r_d, 3);
        chk("dual0_pc", dut1.r_pc, 2);
        wait_ret(0, 4, cyc);
        force_ack = 1'b0;
        chk("dual1_lat", cyc, 1);
        chk("dual1_a", dut1.r_a, 5);
        chk("dual1_d", dut1.r_d, 8);
        chk("dual1_pc", dut1.r_pc, 4);
        chk("dual1_instret", instret1, 4);
        chk("dual_no_req", req_seen, 0);

        // Read-modify-write: read ack in 3rd cycle, write ack in 2nd cycle
        cyc = 0; wr_first = 0;
        while (instret1 < 6 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (bus1.dm_req) begin
                chk("rmw_addr", bus1.dm_addr, 100);
                if (bus1.dm_we && wr_first == 0) wr_first = cyc;
                if (bus1.dm_we && bus1.dm_ack) chk("rmw_wdata", bus1.dm_wdata, 42);
            end
        end
        chk("rmw_lat", cyc, 6);
        chk("rmw_wr_to_retire", cyc - wr_first, 2);
        chk("rmw_mem", mem[100], 42);
        chk("rmw_a", dut1.r_a, 100);
        chk("rmw_d", dut1.r_d, 8);
        chk("rmw_pc", dut1.r_pc, 6);
        chk("rmw_instret", instret1, 6);

        // Jump slot blocks pairing; D=0 takes JEQ back to 7
        wait_ret(0, 8, cyc);
        chk("w3_d", dut1.r_d, 0);
        chk("w3_pc", dut1.r_pc, 8);
        wait_ret(0, 9, cyc);
        chk("nodual_instret", instret1, 9);
        chk("nodual_pc", dut1.r_pc, 9);
        chk("nodual_a", dut1.r_a, 7);
        wait_ret(0, 10, cyc);
        chk("jeq_pc", dut1.r_pc, 7);
        chk("jeq_halted", halted1, 0);
        wait_ret(0, 11, cyc);
        chk("w3s1_d", dut1.r_d, 7);
        wait_ret(0, 13, cyc);
        chk("jeq_nt_pc", dut1.r_pc, 10);
        wait_ret(0, 14, cyc);
        chk("pre_halt_pc", dut1.r_pc, 11);
        chk("pre_halt", halted1, 0);
        wait_ret(0, 15, cyc);
        chk("halt_lat", cyc, 1);
        chk("halt_set", halted1, 1);
        chk("halt_pc", dut1.r_pc, 11);
        wait_ret(0, 20, cyc);
        chk("halt_sticky", halted1, 1);
        chk("halt_instret", instret1, 20);
        chk("halt_pc_loop", dut1.r_pc, 11);

        // Reset pulse while a read is outstanding
        @(negedge clk);
        resetN = 1'b0;
        rom1[0] = {c_ins(1'b0, 6'b110000, 3'b010, 3'b000), a_ins(15'd50)};  // @50 ; D=A
        rom1[1] = {c_ins(1'b1, 6'b110000, 3'b010, 3'b000), a_ins(15'd50)};  // @50 ; D=M
        rd_lat = 10;
        @(negedge clk);
        resetN = 1'b1;
        wait_ret(0, 2, cyc);
        chk("pre_rst_a", dut1.r_a, 50);
        cyc = 0;
        while (!bus1.dm_req && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("rd_req", bus1.dm_req, 1);
        chk("rd_we", bus1.dm_we, 0);
        chk("rd_addr", bus1.dm_addr, 50);
        @(negedge clk);
        #2 resetN = 1'b0;
        #1;
        chk("rst_mid_req", bus1.dm_req, 0);
        chk("rst_mid_addr", addr1, 0);
        chk("rst_mid_pc", dut1.r_pc, 0);
        chk("rst_mid_a", dut1.r_a, 0);
        chk("rst_mid_d", dut1.r_d, 0);
        chk("rst_mid_instret", instret1, 0);
        rd_lat = 2;
        @(negedge clk);
        resetN = 1'b1;
        wait_ret(0, 2, cyc);
        chk("restart_lat", cyc, 2);
        chk("restart_d", dut1.r_d, 50);
        wait_ret(0, 4, cyc);
        chk("rd_lat", cyc, 3);
        chk("rd_d", dut1.r_d, 1234);
        chk("rd_a", dut1.r_a, 50);
        chk("rd_pc", dut1.r_pc, 4);

        // Single-issue 24-bit core
        req_seen = 0;
        @(negedge clk);
        resetN2 = 1'b1;
        wait_ret(1, 1, cyc);
        chk("w24_a", dut2.r_a, 32'h007FFF);
        chk("w24_instret1", instret2, 1);
        chk("w24_pc1", dut2.r_pc, 1);
        wait_ret(1, 2, cyc);
        chk("w24_notA", dut2.r_d, 32'hFF8000);
        chk("w24_instret2", instret2, 2);
        wait_ret(1, 3, cyc);
        chk("w24_instret3", instret2, 3);
        chk("w24_a3", dut2.r_a, 3);
        wait_ret(1, 4, cyc);
        chk("w24_add", dut2.r_d, 32'hFF8003);
        wait_ret(1, 6, cyc);
        chk("w24_halt", halted2, 1);
        chk("w24_halt_pc", dut2.r_pc, 5);
        wait_ret(1, 8, cyc);
        chk("w24_instret8", instret2, 8);
        chk("w24_no_req", req_seen, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
